// File: rtl/add_share_arb.sv
// add_share_arb: two-requester round-robin arbiter in front of one shared adder.
// Each requester hands over an operand pair and gets back sum/overflow on its
// own response channel; only one addition is in flight at a time.
// Optional build macro ADD_SHARE_ARB_STATS_EN adds per-requester saturating
// counters of completed responses and of responses that carried overflow.
//
// state | meaning
// IDLE  | waiting for a command; grant is picked combinationally
// ISSUE | add_en high for one cycle with latched operands
// WAIT  | down-counting adder latency; capture result at terminal count
// RESP  | owner's response held until its ready handshake
module add_share_arb #(
    parameter int DW      = 32,
    parameter int ADD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic [DW-1:0] rsp0_sum,
    output logic          rsp0_ovf,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [DW-1:0] rsp1_sum,
    output logic          rsp1_ovf,
    output logic          add_en,
    output logic [DW-1:0] add_in1,
    output logic [DW-1:0] add_in2,
    input  logic [DW-1:0] add_sum,
    input  logic          add_ovf
`ifdef ADD_SHARE_ARB_STATS_EN
    ,
    output logic [15:0]   cnt0,
    output logic [15:0]   cnt1,
    output logic [15:0]   ovf_cnt0,
    output logic [15:0]   ovf_cnt1
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int CW = 4;

    state_t        state;
    logic          owner;
    logic          ptr;
    logic [CW-1:0] lat_cnt;
    logic          grant_vld;
    logic          grant;

    // Grant: a lone requester wins; on contention the pointer decides.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant     = (req0_valid & req1_valid) ? ptr : req1_valid;
    end

    // Ready is only offered in IDLE and never while reset is held.
    assign req0_ready = !rst && (state == IDLE) && grant_vld && !grant;
    assign req1_ready = !rst && (state == IDLE) && grant_vld && grant;

    // Arbitration FSM with registered adder drive and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            ptr        <= 1'b0;
            lat_cnt    <= '0;
            add_en     <= 1'b0;
            add_in1    <= '0;
            add_in2    <= '0;
            rsp0_valid <= 1'b0;
            rsp0_sum   <= '0;
            rsp0_ovf   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_sum   <= '0;
            rsp1_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        add_in1 <= grant ? req1_a : req0_a;
                        add_in2 <= grant ? req1_b : req0_b;
                        owner   <= grant;
                        ptr     <= ~grant;
                        add_en  <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    add_en  <= 1'b0;
                    lat_cnt <= CW'(ADD_LAT - 1);
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        if (owner) begin
                            rsp1_sum   <= add_sum;
                            rsp1_ovf   <= add_ovf;
                            rsp1_valid <= 1'b1;
                        end else begin
                            rsp0_sum   <= add_sum;
                            rsp0_ovf   <= add_ovf;
                            rsp0_valid <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (owner && rsp1_ready) begin
                        rsp1_valid <= 1'b0;
                        state      <= IDLE;
                    end else if (!owner && rsp0_ready) begin
                        rsp0_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADD_SHARE_ARB_STATS_EN
    logic hs0;
    logic hs1;

    // Response valid is only ever high in RESP for the owner.
    assign hs0 = rsp0_valid & rsp0_ready;
    assign hs1 = rsp1_valid & rsp1_ready;

    // Saturating handshake and overflow counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0     <= '0;
            cnt1     <= '0;
            ovf_cnt0 <= '0;
            ovf_cnt1 <= '0;
        end else begin
            if (hs0 && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
            if (hs1 && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
            if (hs0 && rsp0_ovf && ovf_cnt0 != 16'hFFFF) ovf_cnt0 <= ovf_cnt0 + 16'd1;
            if (hs1 && rsp1_ovf && ovf_cnt1 != 16'hFFFF) ovf_cnt1 <= ovf_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_add_share_arb.sv
// Bench for add_share_arb: two instances (adder latency 1 and 4) driven with
// random traffic, each with its own latency-accurate adder model, compared
// every cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_add_share_arb;

    localparam int L0 = 1;
    localparam int L1 = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_v  [2][2];
    logic        req_rdy[2][2];
    logic [31:0] req_a  [2][2];
    logic [31:0] req_b  [2][2];
    logic        rsp_v  [2][2];
    logic        rsp_rdy[2][2];
    logic [31:0] rsp_s  [2][2];
    logic        rsp_o  [2][2];
    logic        add_en [2];
    logic [31:0] add_in1[2];
    logic [31:0] add_in2[2];
    logic [31:0] add_sum[2];
    logic        add_ovf[2];
`ifdef ADD_SHARE_ARB_STATS_EN
    logic [15:0] st_cnt[2][2];
    logic [15:0] st_ovf[2][2];
`endif

    always #5 clk = ~clk;

    add_share_arb #(.DW(32), .ADD_LAT(L0)) u_lat1 (
        .clk(clk), .rst(rst),
        .req0_valid(req_v[0][0]), .req0_ready(req_rdy[0][0]), .req0_a(req_a[0][0]), .req0_b(req_b[0][0]),
        .rsp0_valid(rsp_v[0][0]), .rsp0_ready(rsp_rdy[0][0]), .rsp0_sum(rsp_s[0][0]), .rsp0_ovf(rsp_o[0][0]),
        .req1_valid(req_v[0][1]), .req1_ready(req_rdy[0][1]), .req1_a(req_a[0][1]), .req1_b(req_b[0][1]),
        .rsp1_valid(rsp_v[0][1]), .rsp1_ready(rsp_rdy[0][1]), .rsp1_sum(rsp_s[0][1]), .rsp1_ovf(rsp_o[0][1]),
        .add_en(add_en[0]), .add_in1(add_in1[0]), .add_in2(add_in2[0]),
        .add_sum(add_sum[0]), .add_ovf(add_ovf[0])
`ifdef ADD_SHARE_ARB_STATS_EN
        , .cnt0(st_cnt[0][0]), .cnt1(st_cnt[0][1]), .ovf_cnt0(st_ovf[0][0]), .ovf_cnt1(st_ovf[0][1])
`endif
    );

    add_share_arb #(.DW(32), .ADD_LAT(L1)) u_lat4 (
        .clk(clk), .rst(rst),
        .req0_valid(req_v[1][0]), .req0_ready(req_rdy[1][0]), .req0_a(req_a[1][0]), .req0_b(req_b[1][0]),
        .rsp0_valid(rsp_v[1][0]), .rsp0_ready(rsp_rdy[1][0]), .rsp0_sum(rsp_s[1][0]), .rsp0_ovf(rsp_o[1][0]),
        .req1_valid(req_v[1][1]), .req1_ready(req_rdy[1][1]), .req1_a(req_a[1][1]), .req1_b(req_b[1][1]),
        .rsp1_valid(rsp_v[1][1]), .rsp1_ready(rsp_rdy[1][1]), .rsp1_sum(rsp_s[1][1]), .rsp1_ovf(rsp_o[1][1]),
        .add_en(add_en[1]), .add_in1(add_in1[1]), .add_in2(add_in2[1]),
        .add_sum(add_sum[1]), .add_ovf(add_ovf[1])
`ifdef ADD_SHARE_ARB_STATS_EN
        , .cnt0(st_cnt[1][0]), .cnt1(st_cnt[1][1]), .ovf_cnt0(st_ovf[1][0]), .ovf_cnt1(st_ovf[1][1])
`endif
    );

    function automatic logic sovf(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        s = a + b;
        return (a[31] == b[31]) && (s[31] != a[31]);
    endfunction

    // Adder models: result appears exactly LAT cycles after the enable sample
    // and only for one cycle; otherwise the outputs carry junk.
    logic        pipe_v[2][16];
    logic [31:0] pipe_s[2][16];
    logic        pipe_o[2][16];
    logic [31:0] junk  [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int k = 15; k > 0; k--) begin
                pipe_v[i][k] <= pipe_v[i][k-1];
                pipe_s[i][k] <= pipe_s[i][k-1];
                pipe_o[i][k] <= pipe_o[i][k-1];
            end
            pipe_v[i][0] <= add_en[i];
            pipe_s[i][0] <= add_in1[i] + add_in2[i];
            pipe_o[i][0] <= sovf(add_in1[i], add_in2[i]);
            junk[i]      <= $urandom;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            add_sum[i] = pipe_v[i][(i == 0) ? L0-1 : L1-1] ? pipe_s[i][(i == 0) ? L0-1 : L1-1] : junk[i];
            add_ovf[i] = pipe_v[i][(i == 0) ? L0-1 : L1-1] ? pipe_o[i][(i == 0) ? L0-1 : L1-1] : junk[i][0];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction per instance, response due
    // ADD_LAT+1 edges after acceptance, held until the owner's ready.
    int          cyc;
    logic        m_busy [2];
    logic        m_owner[2];
    logic        m_ptr  [2];
    int          m_tacc [2];
    logic [31:0] m_a    [2];
    logic [31:0] m_b    [2];
    logic        e_v    [2][2];
    logic [31:0] e_s    [2][2];
    logic        e_o    [2][2];
    int          e_cnt  [2][2];
    int          e_ocnt [2][2];
    logic        e_rdy  [2][2];

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 7))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            4: return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0; m_owner[i] = 1'b0; m_ptr[i] = 1'b0; m_tacc[i] = 0;
            m_a[i] = '0; m_b[i] = '0;
            for (int r = 0; r < 2; r++) begin
                e_v[i][r] = 1'b0; e_s[i][r] = '0; e_o[i][r] = 1'b0;
                e_cnt[i][r] = 0; e_ocnt[i][r] = 0;
            end
        end
    endtask

    initial begin
        int pv, pr, lat;
        logic       acc [2];
        logic       gnt [2];
        logic       hs  [2];
        logic [31:0] ga [2];
        logic [31:0] gb [2];

        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 16; k++) pipe_v[i][k] = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < 2; r++) begin
                req_v[i][r] = 1'b0; req_a[i][r] = '0; req_b[i][r] = '0; rsp_rdy[i][r] = 1'b0;
            end
        repeat (3) @(posedge clk);
        model_reset();
        cyc = 0;
        #1;

        for (int ph = 0; ph < 4; ph++) begin
            pv = (ph == 0) ? 90 : (ph == 1) ? 30 : (ph == 2) ? 100 : 60;
            pr = (ph == 0) ? 80 : (ph == 1) ? 30 : (ph == 2) ? 10 : 100;
            for (int n = 0; n < 1500; n++) begin
                // drive
                rst = (n < 2 && ph == 0) || ($urandom_range(0, 99) < 1);
                for (int i = 0; i < 2; i++)
                    for (int r = 0; r < 2; r++) begin
                        req_v[i][r]   = ($urandom_range(0, 99) < pv);
                        req_a[i][r]   = pick_op();
                        req_b[i][r]   = pick_op();
                        rsp_rdy[i][r] = ($urandom_range(0, 99) < pr);
                    end
                #1;
                // check
                for (int i = 0; i < 2; i++) begin
                    e_rdy[i][0] = !rst && !m_busy[i] && req_v[i][0] && (!req_v[i][1] || !m_ptr[i]);
                    e_rdy[i][1] = !rst && !m_busy[i] && req_v[i][1] && (!req_v[i][0] ||  m_ptr[i]);
                    check($sformatf("i%0d add_en", i), 32'(add_en[i]), 32'(m_busy[i] && cyc == m_tacc[i]));
                    check($sformatf("i%0d add_in1", i), add_in1[i], m_a[i]);
                    check($sformatf("i%0d add_in2", i), add_in2[i], m_b[i]);
                    for (int r = 0; r < 2; r++) begin
                        check($sformatf("i%0d req%0d_ready", i, r), 32'(req_rdy[i][r]), 32'(e_rdy[i][r]));
                        check($sformatf("i%0d rsp%0d_valid", i, r), 32'(rsp_v[i][r]), 32'(e_v[i][r]));
                        check($sformatf("i%0d rsp%0d_sum", i, r), rsp_s[i][r], e_s[i][r]);
                        check($sformatf("i%0d rsp%0d_ovf", i, r), 32'(rsp_o[i][r]), 32'(e_o[i][r]));
`ifdef ADD_SHARE_ARB_STATS_EN
                        check($sformatf("i%0d cnt%0d", i, r), 32'(st_cnt[i][r]), 32'(e_cnt[i][r]));
                        check($sformatf("i%0d ovf_cnt%0d", i, r), 32'(st_ovf[i][r]), 32'(e_ocnt[i][r]));
`endif
                    end
                    acc[i] = e_rdy[i][0] || e_rdy[i][1];
                    gnt[i] = e_rdy[i][1];
                    ga[i]  = req_a[i][gnt[i]];
                    gb[i]  = req_b[i][gnt[i]];
                    hs[i]  = m_busy[i] && e_v[i][m_owner[i]] && rsp_rdy[i][m_owner[i]];
                end
                // advance model across the edge
                @(posedge clk);
                cyc++;
                if (rst) begin
                    model_reset();
                end else begin
                    for (int i = 0; i < 2; i++) begin
                        lat = (i == 0) ? L0 : L1;
                        if (hs[i]) begin
                            e_v[i][m_owner[i]] = 1'b0;
                            m_busy[i] = 1'b0;
                            if (e_cnt[i][m_owner[i]] < 65535) e_cnt[i][m_owner[i]]++;
                            if (e_o[i][m_owner[i]] && e_ocnt[i][m_owner[i]] < 65535) e_ocnt[i][m_owner[i]]++;
                        end
                        if (acc[i]) begin
                            m_busy[i]  = 1'b1;
                            m_owner[i] = gnt[i];
                            m_ptr[i]   = !gnt[i];
                            m_tacc[i]  = cyc;
                            m_a[i]     = ga[i];
                            m_b[i]     = gb[i];
                        end else if (m_busy[i] && cyc == m_tacc[i] + lat + 1) begin
                            e_v[i][m_owner[i]] = 1'b1;
                            e_s[i][m_owner[i]] = m_a[i] + m_b[i];
                            e_o[i][m_owner[i]] = sovf(m_a[i], m_b[i]);
                        end
                    end
                end
                #1;
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
